hazard_fwd_unit: RTL and testbench

- Generates the bypass-enable and load-use stall controls consumed by the decode-stage register file.
- Keeps a shadow pipeline of destination-register info (EX, MEM, WB) and compares it against the source IDs of the instruction in decode.
- Issues per-operand bypass selects encoded {ra, rb}, a decode stall, and an EX bubble.
- Counts stall cycles for performance measurement.

---
 rtl/hazard_fwd_unit.sv | 129 ++++++++++++
 tb/tb_hazard_fwd_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Decode-stage hazard unit: operand bypass selects, load-use stall
// and a saturating stall counter, driven by a shadow EX/MEM/WB pipe.
module hazard_fwd_unit #(
    parameter int ADDR_SIZE = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 D_valid,
    input  logic [ADDR_SIZE-1:0] D_ra,
    input  logic [ADDR_SIZE-1:0] D_rb,
    input  logic                 D_use_ra,
    input  logic                 D_use_rb,
    input  logic [ADDR_SIZE-1:0] D_rd,
    input  logic                 D_we,
    input  logic                 D_ld,
    input  logic                 flush,
    output logic [1:0]           EX_D_bp,
    output logic [1:0]           MEM_D_bp,
    output logic [1:0]           WB_D_bp,
    output logic                 stall,
    output logic                 EX_bubble,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef struct packed {
        logic                 v;
        logic                 we;
        logic [ADDR_SIZE-1:0] rd;
        logic                 ld;
    } shadow_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    shadow_t ex_q;
    shadow_t mem_q;
    shadow_t wb_q;
    shadow_t ex_d;
    logic    bubble_d;

    logic ra_live;
    logic rb_live;
    logic hit_ex_ra;
    logic hit_ex_rb;
    logic hit_mem_ra;
    logic hit_mem_rb;
    logic hit_wb_ra;
    logic hit_wb_rb;
    logic lu;

    // Source operands that can ever hit: real, read, and not x0.
    always_comb begin
        ra_live = D_valid & D_use_ra & (D_ra != '0);
        rb_live = D_valid & D_use_rb & (D_rb != '0);
    end

    // Compare decode sources against every shadow stage destination.
    always_comb begin
        hit_ex_ra  = ra_live & ex_q.v & ex_q.we
                   & (ex_q.rd == D_ra);
        hit_ex_rb  = rb_live & ex_q.v & ex_q.we
                   & (ex_q.rd == D_rb);
        hit_mem_ra = ra_live & mem_q.v & mem_q.we
                   & (mem_q.rd == D_ra);
        hit_mem_rb = rb_live & mem_q.v & mem_q.we
                   & (mem_q.rd == D_rb);
        hit_wb_ra  = ra_live & wb_q.v & wb_q.we
                   & (wb_q.rd == D_ra);
        hit_wb_rb  = rb_live & wb_q.v & wb_q.we
                   & (wb_q.rd == D_rb);
    end

    // Youngest producer wins; a load in EX blocks every older source
    // for that operand because its value is not ready yet.
    always_comb begin
        EX_D_bp[1]  = hit_ex_ra & ~ex_q.ld;
        EX_D_bp[0]  = hit_ex_rb & ~ex_q.ld;
        MEM_D_bp[1] = hit_mem_ra & ~hit_ex_ra;
        MEM_D_bp[0] = hit_mem_rb & ~hit_ex_rb;
        WB_D_bp[1]  = hit_wb_ra & ~hit_ex_ra & ~hit_mem_ra;
        WB_D_bp[0]  = hit_wb_rb & ~hit_ex_rb & ~hit_mem_rb;
        lu          = (hit_ex_ra | hit_ex_rb) & ex_q.ld;
        stall       = lu & ~flush;
    end

    // Next EX entry: a squashed or held decode becomes a bubble.
    always_comb begin
        ex_d     = '0;
        bubble_d = 1'b0;
        unique case (1'b1)
            flush, stall: begin
                ex_d     = '0;
                bubble_d = 1'b1;
            end
            default: begin
                ex_d.v   = D_valid;
                ex_d.we  = D_we & D_valid;
                ex_d.rd  = D_rd;
                ex_d.ld  = D_ld & D_valid;
                bubble_d = 1'b0;
            end
        endcase
    end

    // Shadow pipe advances every cycle; older stages never stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            EX_bubble <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= ex_q;
            wb_q      <= mem_q;
            EX_bubble <= bubble_d;
        end
    end

    // Stall cycle counter, pinned at all-ones once full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed scenarios plus random traffic
// against a stage-list reference model; a 4-bit counter copy saturates.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       D_valid;
    logic [4:0] D_ra;
    logic [4:0] D_rb;
    logic       D_use_ra;
    logic       D_use_rb;
    logic [4:0] D_rd;
    logic       D_we;
    logic       D_ld;
    logic       flush;

    logic [1:0]  EX_D_bp;
    logic [1:0]  MEM_D_bp;
    logic [1:0]  WB_D_bp;
    logic        stall;
    logic        EX_bubble;
    logic [31:0] stall_cnt;

    logic [1:0] EX_D_bp_s;
    logic [1:0] MEM_D_bp_s;
    logic [1:0] WB_D_bp_s;
    logic       stall_s;
    logic       EX_bubble_s;
    logic [3:0] stall_cnt_s;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit u_dut (
        .clk(clk), .rst_n(rst_n), .D_valid(D_valid),
        .D_ra(D_ra), .D_rb(D_rb),
        .D_use_ra(D_use_ra), .D_use_rb(D_use_rb),
        .D_rd(D_rd), .D_we(D_we), .D_ld(D_ld), .flush(flush),
        .EX_D_bp(EX_D_bp), .MEM_D_bp(MEM_D_bp), .WB_D_bp(WB_D_bp),
        .stall(stall), .EX_bubble(EX_bubble), .stall_cnt(stall_cnt)
    );

    hazard_fwd_unit #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .D_valid(D_valid),
        .D_ra(D_ra), .D_rb(D_rb),
        .D_use_ra(D_use_ra), .D_use_rb(D_use_rb),
        .D_rd(D_rd), .D_we(D_we), .D_ld(D_ld), .flush(flush),
        .EX_D_bp(EX_D_bp_s), .MEM_D_bp(MEM_D_bp_s),
        .WB_D_bp(WB_D_bp_s), .stall(stall_s),
        .EX_bubble(EX_bubble_s), .stall_cnt(stall_cnt_s)
    );

    // Reference model: list of in-flight instructions, index 0 = EX.
    typedef struct {
        bit v;
        bit we;
        int rd;
        bit ld;
    } ent_t;

    ent_t        pipe[3];
    bit          m_bub;
    int unsigned nstall;
    logic [1:0]  e_bp[3];
    logic        e_stall;

    function automatic logic [3:0] sat4();
        return (nstall > 15) ? 4'hF : nstall[3:0];
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
        m_bub  = 0;
        nstall = 0;
    endfunction

    // Walk stages from youngest to oldest; first producer decides.
    function automatic void model_eval();
        bit lu = 0;
        for (int s = 0; s < 3; s++) e_bp[s] = 2'b00;
        for (int op = 0; op < 2; op++) begin
            int  id    = (op == 0) ? int'(D_ra) : int'(D_rb);
            bit  used  = (op == 0) ? D_use_ra : D_use_rb;
            int  bpos  = (op == 0) ? 1 : 0;
            bit  found = 0;
            if (D_valid && used && id != 0) begin
                for (int s = 0; s < 3; s++) begin
                    if (!found && pipe[s].v && pipe[s].we
                        && pipe[s].rd == id) begin
                        found = 1;
                        if (s == 0 && pipe[0].ld) lu = 1;
                        else e_bp[s][bpos] = 1'b1;
                    end
                end
            end
        end
        e_stall = lu && !flush;
    endfunction

    function automatic void model_adv();
        if (e_stall) nstall++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (flush || e_stall) begin
            pipe[0] = '{0, 0, 0, 0};
            m_bub   = 1;
        end else begin
            pipe[0] = '{D_valid, D_we && D_valid,
                        int'(D_rd), D_ld && D_valid};
            m_bub   = 0;
        end
    endfunction

    task automatic drive(input logic v, input logic [4:0] ra,
                         input logic [4:0] rb, input logic ua,
                         input logic ub, input logic [4:0] rd,
                         input logic we, input logic ld,
                         input logic fl);
        D_valid  = v;
        D_ra     = ra;
        D_rb     = rb;
        D_use_ra = ua;
        D_use_rb = ub;
        D_rd     = rd;
        D_we     = we;
        D_ld     = ld;
        flush    = fl;
    endtask

    task automatic look();
        @(negedge clk);
        model_eval();
    endtask

    task automatic adv();
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        look();
        adv();
    endtask

    task automatic test_reset();
        drive(1, 3, 3, 1, 1, 3, 1, 1, 0);
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({EX_D_bp, MEM_D_bp, WB_D_bp, stall, EX_bubble} !== 8'h00
            || stall_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: bp=%b/%b/%b stall=%b bub=%b cnt=%0d, want all 0",
                     EX_D_bp, MEM_D_bp, WB_D_bp, stall, EX_bubble, stall_cnt);
        end
        rst_n = 1'b1;
        nop();
        look();
        n_vec++;
        if (EX_bubble !== 1'b0 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: stall=%b bub=%b, want 0/0",
                     stall, EX_bubble);
        end
        adv();
    endtask

    task automatic test_ex_forward();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        look();
        adv();
        drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
        look();
        n_vec++;
        if (EX_D_bp !== 2'b10 || MEM_D_bp !== 2'b00
            || WB_D_bp !== 2'b00 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL ex_forward: bp=%b/%b/%b stall=%b, want 10/00/00 0",
                     EX_D_bp, MEM_D_bp, WB_D_bp, stall);
        end
        adv();
    endtask

    task automatic test_priority();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        look();
        adv();
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
        look();
        adv();
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
        look();
        adv();
        drive(1, 4, 5, 1, 1, 0, 0, 0, 0);
        look();
        n_vec++;
        if (EX_D_bp !== 2'b10 || MEM_D_bp !== 2'b00
            || WB_D_bp !== 2'b01 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL priority: bp=%b/%b/%b stall=%b, want 10/00/01 0",
                     EX_D_bp, MEM_D_bp, WB_D_bp, stall);
        end
        adv();
    endtask

    task automatic test_load_use();
        int unsigned c0;
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        look();
        adv();
        c0 = nstall;
        drive(1, 0, 7, 0, 1, 0, 0, 0, 0);
        look();
        n_vec++;
        if (stall !== 1'b1 || EX_D_bp !== 2'b00
            || MEM_D_bp !== 2'b00 || WB_D_bp !== 2'b00
            || stall_cnt !== c0) begin
            n_bad++;
            $display("FAIL load_use_c0: stall=%b bp=%b/%b/%b cnt=%0d, want 1 00/00/00 %0d",
                     stall, EX_D_bp, MEM_D_bp, WB_D_bp, stall_cnt, c0);
        end
        adv();
        look();
        n_vec++;
        if (EX_bubble !== 1'b1 || MEM_D_bp !== 2'b01
            || EX_D_bp !== 2'b00 || stall !== 1'b0
            || stall_cnt !== c0 + 1) begin
            n_bad++;
            $display("FAIL load_use_c1: bub=%b bp=%b/%b stall=%b cnt=%0d, want 1 00/01 0 %0d",
                     EX_bubble, EX_D_bp, MEM_D_bp, stall, stall_cnt, c0 + 1);
        end
        adv();
    endtask

    task automatic test_x0_unused();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        look();
        adv();
        drive(1, 0, 0, 1, 0, 2, 1, 1, 0);
        look();
        n_vec++;
        if ({EX_D_bp, MEM_D_bp, WB_D_bp} !== 6'b0 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL x0_no_hit: bp=%b/%b/%b stall=%b, want 00/00/00 0",
                     EX_D_bp, MEM_D_bp, WB_D_bp, stall);
        end
        adv();
        drive(1, 0, 2, 0, 0, 0, 0, 0, 0);
        look();
        n_vec++;
        if ({EX_D_bp, MEM_D_bp, WB_D_bp} !== 6'b0 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL unused_rb: bp=%b/%b/%b stall=%b, want 00/00/00 0",
                     EX_D_bp, MEM_D_bp, WB_D_bp, stall);
        end
        adv();
    endtask

    task automatic test_flush_load_use();
        int unsigned c0;
        nop();
        nop();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        look();
        adv();
        c0 = nstall;
        drive(1, 0, 7, 0, 1, 0, 0, 0, 1);
        look();
        n_vec++;
        if (stall !== 1'b0 || stall_cnt !== c0) begin
            n_bad++;
            $display("FAIL flush_lu_c0: stall=%b cnt=%0d, want 0 %0d",
                     stall, stall_cnt, c0);
        end
        adv();
        drive(1, 0, 7, 0, 1, 0, 0, 0, 0);
        look();
        n_vec++;
        if (EX_bubble !== 1'b1 || EX_D_bp !== 2'b00
            || MEM_D_bp !== 2'b01 || stall !== 1'b0
            || stall_cnt !== c0) begin
            n_bad++;
            $display("FAIL flush_lu_c1: bub=%b bp=%b/%b stall=%b cnt=%0d, want 1 00/01 0 %0d",
                     EX_bubble, EX_D_bp, MEM_D_bp, stall, stall_cnt, c0);
        end
        adv();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 7) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0));
            look();
            n_vec++;
            if (EX_D_bp !== e_bp[0] || MEM_D_bp !== e_bp[1]
                || WB_D_bp !== e_bp[2] || stall !== e_stall
                || EX_bubble !== m_bub || stall_cnt !== nstall
                || stall_s !== e_stall || stall_cnt_s !== sat4()) begin
                n_bad++;
                $display("FAIL random[%0d]: bp=%b/%b/%b st=%b bub=%b cnt=%0d/%0d, want %b/%b/%b %b %b %0d/%0d",
                         i, EX_D_bp, MEM_D_bp, WB_D_bp, stall, EX_bubble,
                         stall_cnt, stall_cnt_s, e_bp[0], e_bp[1], e_bp[2],
                         e_stall, m_bub, nstall, sat4());
            end
            adv();
        end
        look();
        n_vec++;
        if (nstall < 16 || stall_cnt_s !== 4'hF) begin
            n_bad++;
            $display("FAIL saturation: cnt4=%0d stalls=%0d, want 15 with >15 stalls",
                     stall_cnt_s, nstall);
        end
        adv();
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        look();
        adv();
        drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
        look();
        n_vec++;
        if (EX_D_bp !== 2'b10 || stall_cnt !== nstall) begin
            n_bad++;
            $display("FAIL pre_async: ex_bp=%b cnt=%0d, want 10 %0d",
                     EX_D_bp, stall_cnt, nstall);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        n_vec++;
        if ({EX_D_bp, MEM_D_bp, WB_D_bp} !== 6'b0 || stall !== 1'b0
            || EX_bubble !== 1'b0 || stall_cnt !== 32'd0
            || stall_cnt_s !== 4'd0) begin
            n_bad++;
            $display("FAIL async_reset: bp=%b/%b/%b st=%b bub=%b cnt=%0d/%0d, want all 0",
                     EX_D_bp, MEM_D_bp, WB_D_bp, stall, EX_bubble,
                     stall_cnt, stall_cnt_s);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        look();
        n_vec++;
        if (EX_D_bp !== 2'b00 || stall_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL post_async: ex_bp=%b cnt=%0d, want 00 0",
                     EX_D_bp, stall_cnt);
        end
        adv();
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_priority();
        test_load_use();
        test_x0_unused();
        test_flush_load_use();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
